// File: rtl/alu_share_ctrl.sv
// Round-robin front end sharing one external 16-bit ALU between two requesters; accept->rsp_valid in 2 cycles.
// Throughput is one op per 3 cycles; a stalled response holds the block in RESP and blocks new accepts.
module alu_share_ctrl #(
  parameter int   DATA_W  = 16,
  parameter int   OP_W    = 4,
  parameter int   SH_W    = 4,
  parameter logic RR_INIT = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*OP_W-1:0]   req_op,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [2*SH_W-1:0]   req_shd,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_res,
  output logic [3:0]          rsp_szcv,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_op,
  output logic [SH_W-1:0]     alu_shd,
  input  logic [DATA_W-1:0]   alu_res,
  input  logic [3:0]          alu_szcv
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic                prio_q;
  logic                gnt_q;
  logic                gnt_d;
  logic                req_any;
  logic [1:0]          rsp_valid_q;
  logic [DATA_W-1:0]   res_q;
  logic [3:0]          szcv_q;
  logic                err_q;
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic [OP_W-1:0]     alu_op_q;
  logic [SH_W-1:0]     alu_shd_q;

  // Supported opcodes: arithmetic/logic 0..6 and shifts 8..11.
  function automatic logic op_ok(input logic [OP_W-1:0] op);
    return (op <= OP_W'(6)) || ((op >= OP_W'(8)) && (op <= OP_W'(11)));
  endfunction

  always_comb begin
    req_any = |req_valid;
    if (req_valid == 2'b11) begin
      gnt_d = prio_q;
    end else begin
      gnt_d = req_valid[1];
    end
  end

  // Accept is combinational so the handshake closes in the same IDLE cycle.
  assign req_ready = (rst_n && (state_q == IDLE) && req_any) ?
                     (gnt_d ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= RR_INIT;
      gnt_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      res_q       <= '0;
      szcv_q      <= 4'b0000;
      err_q       <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_shd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            gnt_q     <= gnt_d;
            alu_op_q  <= gnt_d ? req_op[2*OP_W-1:OP_W]     : req_op[OP_W-1:0];
            alu_a_q   <= gnt_d ? req_a[2*DATA_W-1:DATA_W]  : req_a[DATA_W-1:0];
            alu_b_q   <= gnt_d ? req_b[2*DATA_W-1:DATA_W]  : req_b[DATA_W-1:0];
            alu_shd_q <= gnt_d ? req_shd[2*SH_W-1:SH_W]    : req_shd[SH_W-1:0];
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          if (op_ok(alu_op_q)) begin
            res_q  <= alu_res;
            szcv_q <= alu_szcv;
            err_q  <= 1'b0;
          end else begin
            res_q  <= '0;
            szcv_q <= 4'b0000;
            err_q  <= 1'b1;
          end
          rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready[gnt_q]) begin
            rsp_valid_q <= 2'b00;
            prio_q      <= ~gnt_q;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = res_q;
  assign rsp_szcv  = szcv_q;
  assign rsp_err   = err_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_shd   = alu_shd_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a small behavioural ALU attached to the alu_* ports.
module tb_alu_share_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  req_shd;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_res;
  logic [3:0]  rsp_szcv;
  logic        rsp_err;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [3:0]  alu_shd;
  logic [15:0] alu_res;
  logic [3:0]  alu_szcv;

  int tests = 0;
  int fails = 0;

  alu_share_ctrl #(.DATA_W(16), .OP_W(4), .SH_W(4), .RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shd(req_shd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_szcv(rsp_szcv), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shd(alu_shd),
    .alu_res(alu_res), .alu_szcv(alu_szcv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: flags {S,Z,C,V}; SUB carry = borrow; shifts act on b by alu_shd.
  logic [16:0] t17;
  logic        c_f;
  logic        v_f;
  always_comb begin
    t17 = 17'd0;
    c_f = 1'b0;
    v_f = 1'b0;
    case (alu_op)
      4'd0: begin
        t17 = {1'b0, alu_a} + {1'b0, alu_b};
        c_f = t17[16];
        v_f = (alu_a[15] == alu_b[15]) && (t17[15] != alu_a[15]);
      end
      4'd1, 4'd6: begin
        t17 = {1'b0, alu_a} - {1'b0, alu_b};
        c_f = alu_a < alu_b;
        v_f = (alu_a[15] != alu_b[15]) && (t17[15] != alu_a[15]);
      end
      4'd2: t17 = {1'b0, alu_a & alu_b};
      4'd3: t17 = {1'b0, alu_a | alu_b};
      4'd4: t17 = {1'b0, alu_a ^ alu_b};
      4'd5: t17 = {1'b0, ~alu_a};
      4'd8: begin
        t17 = {1'b0, alu_b} << alu_shd;
        c_f = t17[16];
      end
      4'd9: begin
        t17 = {1'b0, alu_b >> alu_shd};
      end
      4'd10: t17 = {1'b0, $unsigned($signed(alu_b) >>> alu_shd)};
      4'd11: t17 = {1'b0, (alu_b << alu_shd) | (alu_b >> (5'd16 - {1'b0, alu_shd}))};
      default: begin
        t17 = {1'b0, alu_a ^ alu_b};
        c_f = 1'b1;
        v_f = 1'b1;
      end
    endcase
  end
  assign alu_res  = t17[15:0];
  assign alu_szcv = {t17[15], (t17[15:0] == 16'd0), c_f, v_f};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] shd);
    req_op[i*4 +: 4]   = op;
    req_a[i*16 +: 16]  = a;
    req_b[i*16 +: 16]  = b;
    req_shd[i*4 +: 4]  = shd;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_shd   = '0;
    rsp_ready = 2'b00;
    tick();
    tick();
    // Reset state
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_res", rsp_res, 16'h0);
    chk("rst_szcv_err", {rsp_szcv, rsp_err}, 5'h0);
    chk("rst_alu_regs", {alu_a, alu_b, alu_op, alu_shd}, 40'h0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();

    // 1. Single op: ADD 3+5
    set_req(0, 4'd0, 16'd3, 16'd5, 4'd0);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    #1 chk("t1_req_ready_T", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("t1_exec_no_rsp", rsp_valid, 2'b00);
    chk("t1_alu_regs", {alu_op, alu_a, alu_b}, {4'd0, 16'd3, 16'd5});
    tick();
    chk("t1_rsp_valid_T2", rsp_valid, 2'b01);
    chk("t1_res", rsp_res, 16'd8);
    chk("t1_szcv", rsp_szcv, 4'b0000);
    tick();
    chk("t1_back_idle", rsp_valid, 2'b00);

    // 2. Contention right after reset: req0 wins, then req1, then req0 again
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req(0, 4'd1, 16'd1, 16'd1, 4'd0);
    set_req(1, 4'd2, 16'hF0F0, 16'h0FF0, 4'd0);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1 chk("t2_first_grant", req_ready, 2'b01);
    tick();
    chk("t2_exec_ready0", req_ready, 2'b00);
    tick();
    chk("t2_rsp0_valid", rsp_valid, 2'b01);
    chk("t2_rsp0_res", rsp_res, 16'h0000);
    chk("t2_rsp0_szcv", rsp_szcv, 4'b0100);
    chk("t2_resp_ready0", req_ready, 2'b00);
    tick();
    chk("t2_second_grant", req_ready, 2'b10);
    tick();
    tick();
    chk("t2_rsp1_valid", rsp_valid, 2'b10);
    chk("t2_rsp1_res", rsp_res, 16'h00F0);
    chk("t2_rsp1_szcv", rsp_szcv, 4'b0000);
    tick();
    chk("t2_third_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    set_req(0, 4'd0, 16'd5, 16'd9, 4'd0);
    tick();
    chk("t2_sampled_once", {rsp_valid, rsp_res}, {2'b01, 16'h0000});
    tick();

    // 3. Back-pressure on req0 while req1 waits with an illegal opcode
    set_req(0, 4'd0, 16'd3, 16'd5, 4'd0);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    #1 chk("t3_grant", req_ready, 2'b01);
    tick();
    set_req(1, 4'hF, 16'h1234, 16'h5678, 4'd3);
    req_valid = 2'b10;
    tick();
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold", {rsp_valid, req_ready, rsp_res, rsp_szcv}, {2'b01, 2'b00, 16'd8, 4'b0000});
      tick();
    end
    rsp_ready = 2'b01;
    tick();

    // 4. Illegal opcode on req1, then legal op on req0
    chk("t4_grant1", req_ready, 2'b10);
    rsp_ready = 2'b11;
    tick();
    req_valid = 2'b00;
    tick();
    chk("t4_err_rsp", {rsp_valid, rsp_err, rsp_res, rsp_szcv}, {2'b10, 1'b1, 16'h0, 4'h0});
    tick();

    // 5. Overflow and shift flag pass-through
    set_req(0, 4'd0, 16'h7FFF, 16'h0001, 4'd0);
    req_valid = 2'b01;
    #1 chk("t5_grant0", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t5_add_ovf", {rsp_valid, rsp_err, rsp_res, rsp_szcv}, {2'b01, 1'b0, 16'h8000, 4'b1001});
    tick();
    set_req(0, 4'd8, 16'h0000, 16'h8001, 4'd1);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("t5_sll_regs", {alu_op, alu_b, alu_shd}, {4'd8, 16'h8001, 4'd1});
    tick();
    chk("t5_sll", {rsp_valid, rsp_res, rsp_szcv}, {2'b01, 16'h0002, 4'b0010});
    tick();

    // 6a. Reset during EXEC (prio was 1 before reset)
    set_req(0, 4'd0, 16'd7, 16'd7, 4'd0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_exec_reset", {rsp_valid, rsp_res, alu_a}, {2'b00, 16'h0, 16'h0});
    tick();
    tick();
    chk("t6_no_stale", rsp_valid, 2'b00);
    req_valid = 2'b11;
    #1 chk("t6_prio_init", req_ready, 2'b01);
    // 6b. Reset during RESP
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    tick();
    req_valid = 2'b00;
    tick();
    chk("t6_resp_reached", rsp_valid, 2'b10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_resp_reset", {rsp_valid, rsp_res, rsp_szcv}, {2'b00, 16'h0, 4'h0});
    rsp_ready = 2'b11;
    tick();
    chk("t6_resp_no_stale", rsp_valid, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
